// File: rtl/multiplier_booth_signed_pkg.sv
// Shared arithmetic package: FSM state encodings and Booth step decode for the
// iterative signed multiplier/divider family.
package multiplier_booth_signed_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EVAL   = 3'd1,
    S_SHIFT  = 3'd2,
    S_ADDEND = 3'd3,
    S_OUTPUT = 3'd4
  } mul_state_e;

  typedef enum logic [2:0] {
    DIV_IDLE   = 3'd0,
    DIV_ITER   = 3'd1,
    DIV_FIX    = 3'd2,
    DIV_OUTPUT = 3'd3
  } div_state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } booth_op_e;

  // Radix-2 Booth recoding of {current multiplier bit, previous bit}.
  function automatic booth_op_e booth_decode(input logic [1:0] pair);
    booth_op_e op;
    unique case (pair)
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multiplier_booth_signed.sv
// Sequential radix-2 Booth signed multiply-accumulate: PRODUCT_OUT = M*Q + C
// at double width, one EVAL/SHIFT pair per multiplier bit.
module multiplier_booth_signed
  import multiplier_booth_signed_pkg::*;
#(
  parameter int WORD_WIDTH = 10
) (
  input  logic                           CLK,
  input  logic                           ARST_N,
  input  logic                           CE,
  input  logic signed [WORD_WIDTH-1:0]   MULTIPLICAND_IN,
  input  logic signed [WORD_WIDTH-1:0]   MULTIPLIER_IN,
  input  logic signed [WORD_WIDTH-1:0]   ADDEND_IN,
  output logic signed [2*WORD_WIDTH-1:0] PRODUCT_OUT,
  input  logic                           start,
  output logic                           busy,
  output logic                           done
);

  localparam int CNT_W  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int PROD_W = 2 * WORD_WIDTH;

  mul_state_e                  state;
  logic signed [WORD_WIDTH:0]  acc;
  logic signed [WORD_WIDTH:0]  m_ext;
  logic [WORD_WIDTH-1:0]       mq;
  logic                        qm1;
  logic signed [WORD_WIDTH-1:0] c_reg;
  logic [CNT_W-1:0]            cnt_bits;
  logic [PROD_W-1:0]           low_word;
  logic [PROD_W-1:0]           addend_ext;

  assign busy       = (state != S_IDLE);
  // The guard bit acc[W] is dropped: the final result always fits in 2W bits.
  assign low_word   = {acc[WORD_WIDTH-1:0], mq};
  assign addend_ext = {{WORD_WIDTH{c_reg[WORD_WIDTH-1]}}, c_reg};

  // Control: state, registered result and done pulse.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state       <= S_IDLE;
      PRODUCT_OUT <= '0;
      done        <= 1'b0;
    end else if (CE) begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) state <= S_EVAL;
        end
        S_EVAL:   state <= S_SHIFT;
        S_SHIFT:  state <= (cnt_bits == '0) ? S_ADDEND : S_EVAL;
        S_ADDEND: state <= S_OUTPUT;
        S_OUTPUT: begin
          PRODUCT_OUT <= $signed(low_word);
          done        <= 1'b1;
          state       <= S_IDLE;
        end
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Datapath: Booth add/sub, combined arithmetic shift, final addend.
  always_ff @(posedge CLK) begin
    if (CE) begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            acc      <= '0;
            mq       <= MULTIPLIER_IN;
            qm1      <= 1'b0;
            m_ext    <= {MULTIPLICAND_IN[WORD_WIDTH-1], MULTIPLICAND_IN};
            c_reg    <= ADDEND_IN;
            cnt_bits <= CNT_W'(WORD_WIDTH - 1);
          end
        end
        S_EVAL: begin
          unique case (booth_decode({mq[0], qm1}))
            OP_ADD:  acc <= acc + m_ext;
            OP_SUB:  acc <= acc - m_ext;
            default: acc <= acc;
          endcase
        end
        S_SHIFT: begin
          {acc, mq, qm1} <= {acc[WORD_WIDTH], acc, mq};
          cnt_bits       <= cnt_bits - 1'b1;
        end
        S_ADDEND: begin
          {acc[WORD_WIDTH-1:0], mq} <= low_word + addend_ext;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
